// File: rtl/mesh_rx_arb_if.sv
// Bundle of link-side and receive-side signals for mesh_rx_arb.
//   in_vld/in_rdy/in_qos : per-link handshake and QoS bit (N_IN wide)
//   in_type/in_src/in_tgt/in_data : per-link fields, link i at [i*W +: W]
//   out_vld/out_rdy      : FIFO head handshake toward the node receive logic
//   out_qos/out_type/out_src/out_tgt/out_data/out_port : FIFO head fields
//   fifo_cnt             : FIFO occupancy 0..2
// Modports: master = environment (links + consumer), slave = the arbiter.
interface mesh_rx_arb_if #(
  parameter int unsigned N_IN   = 7,
  parameter int unsigned TYPE_W = 2,
  parameter int unsigned ID_W   = 6,
  parameter int unsigned FLIT_W = 64
);
  logic [N_IN-1:0]        in_vld;
  logic [N_IN-1:0]        in_rdy;
  logic [N_IN-1:0]        in_qos;
  logic [N_IN*TYPE_W-1:0] in_type;
  logic [N_IN*ID_W-1:0]   in_src;
  logic [N_IN*ID_W-1:0]   in_tgt;
  logic [N_IN*FLIT_W-1:0] in_data;
  logic                   out_vld;
  logic                   out_rdy;
  logic                   out_qos;
  logic [TYPE_W-1:0]      out_type;
  logic [ID_W-1:0]        out_src;
  logic [ID_W-1:0]        out_tgt;
  logic [FLIT_W-1:0]      out_data;
  logic [2:0]             out_port;
  logic [1:0]             fifo_cnt;

  modport master (
    output in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
    input  in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data,
           out_port, fifo_cnt
  );

  modport slave (
    input  in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
    output in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data,
           out_port, fifo_cnt
  );
endinterface

// File: rtl/mesh_rx_arb.sv
// Per-node ingress arbiter for one mesh axis. Picks one of N_IN links per
// cycle (high-QoS class first, round-robin within class) and queues the
// winner in a 2-entry FIFO whose head drives the out_* fields.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : mesh_rx_arb_if.slave (link inputs, grants, FIFO head, fifo_cnt)
// Optional feature: define MESH_RX_QOS_AGING_EN to promote a low-QoS link
// into the high class after it has waited AGE_LIMIT cycles.
// in_rdy is combinational from in_vld/in_qos and registered state only.
module mesh_rx_arb #(
  parameter int unsigned N_IN      = 7,
  parameter int unsigned TYPE_W    = 2,
  parameter int unsigned ID_W      = 6,
  parameter int unsigned FLIT_W    = 64,
  parameter int unsigned AGE_LIMIT = 15
) (
  input logic           clk,
  input logic           rst_n,
  mesh_rx_arb_if.slave  bus
);

  localparam int unsigned PTR_W  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int unsigned PORT_W = 3;

  typedef struct packed {
    logic              qos;
    logic [TYPE_W-1:0] typ;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
    logic [PORT_W-1:0] port;
  } pkt_t;

  logic [PTR_W-1:0] ptr_hi;
  logic [PTR_W-1:0] ptr_lo;
  logic [PTR_W-1:0] ptr_sel;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] ptr_inc;
  logic [N_IN-1:0]  aged;
  logic [N_IN-1:0]  hi;
  logic [N_IN-1:0]  lo;
  logic [N_IN-1:0]  req;
  logic             use_hi;
  logic             found;
  logic             space;
  logic             push;
  logic             pop;
  logic [1:0]       cnt;
  logic [1:0]       cnt_nxt;
  logic             vld_q;
  pkt_t             head;
  pkt_t             tail;
  pkt_t             in_pkt;
  int unsigned      idx;

  // Age counters promote waiting low-QoS links into the high class.
`ifdef MESH_RX_QOS_AGING_EN
  localparam int unsigned AGE_W = (AGE_LIMIT > 0) ? $clog2(AGE_LIMIT + 1) : 1;

  logic [AGE_W-1:0] age [N_IN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (!bus.in_vld[PTR_W'(i)] || bus.in_rdy[PTR_W'(i)]) begin
          age[i] <= '0;
        end else if (!bus.in_qos[PTR_W'(i)] && (age[i] != AGE_W'(AGE_LIMIT))) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    aged = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      aged[PTR_W'(i)] = (age[i] == AGE_W'(AGE_LIMIT));
    end
  end
`else
  // No promotion: strict QoS priority, AGE_LIMIT has no effect here.
  assign aged = {N_IN{1'b0}} & {N_IN{AGE_LIMIT != 0}};
`endif

  // Class selection and round-robin search from the class pointer.
  always_comb begin
    hi      = bus.in_vld & (bus.in_qos | aged);
    lo      = bus.in_vld & ~bus.in_qos & ~aged;
    use_hi  = |hi;
    req     = use_hi ? hi : lo;
    ptr_sel = use_hi ? ptr_hi : ptr_lo;
    win     = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      idx = (32'(ptr_sel) + k) % N_IN;
      if (!found && req[PTR_W'(idx)]) begin
        found = 1'b1;
        win   = PTR_W'(idx);
      end
    end
  end

  // Grants are withheld during reset and whenever the FIFO is full.
  assign space      = rst_n && (cnt != 2'd2);
  assign bus.in_rdy = (space && found) ? (N_IN'(1) << win) : '0;
  assign push       = |bus.in_rdy;
  assign pop        = vld_q && bus.out_rdy;
  assign ptr_inc    = (win == PTR_W'(N_IN - 1)) ? '0 : win + 1'b1;
  assign cnt_nxt    = cnt + 2'(push) - 2'(pop);

  // Winner's fields gathered into the FIFO entry format.
  always_comb begin
    in_pkt      = '0;
    in_pkt.port = PORT_W'(win);
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (win == PTR_W'(i)) begin
        in_pkt.qos  = bus.in_qos[PTR_W'(i)];
        in_pkt.typ  = bus.in_type[i*TYPE_W +: TYPE_W];
        in_pkt.src  = bus.in_src[i*ID_W +: ID_W];
        in_pkt.tgt  = bus.in_tgt[i*ID_W +: ID_W];
        in_pkt.data = bus.in_data[i*FLIT_W +: FLIT_W];
      end
    end
  end

  // Round-robin pointers: only the class that won advances.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_hi <= '0;
      ptr_lo <= '0;
    end else if (push) begin
      if (use_hi) begin
        ptr_hi <= ptr_inc;
      end else begin
        ptr_lo <= ptr_inc;
      end
    end
  end

  // Two-entry FIFO: head is the output register, tail holds the second entry.
  // Head keeps its last value when the FIFO drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= '0;
      vld_q <= 1'b0;
    end else begin
      if (pop && (cnt == 2'd2)) begin
        head <= tail;
      end
      if (push) begin
        if ((cnt == 2'd0) || ((cnt == 2'd1) && pop)) begin
          head <= in_pkt;
        end else begin
          tail <= in_pkt;
        end
      end
      cnt   <= cnt_nxt;
      vld_q <= (cnt_nxt != 2'd0);
    end
  end

  assign bus.out_vld  = vld_q;
  assign bus.fifo_cnt = cnt;
  assign bus.out_qos  = head.qos;
  assign bus.out_type = head.typ;
  assign bus.out_src  = head.src;
  assign bus.out_tgt  = head.tgt;
  assign bus.out_data = head.data;
  assign bus.out_port = head.port;

endmodule

// File: tb/tb_mesh_rx_arb.sv
// Randomized self-checking bench for mesh_rx_arb (default build) against a
// queue-based reference model, plus directed reset/RR/priority/backpressure cases.
module tb_mesh_rx_arb;

  localparam int N = 7;

  logic clk;
  logic rst_n;

  mesh_rx_arb_if #(.N_IN(7), .TYPE_W(2), .ID_W(6), .FLIT_W(64)) bus ();

  mesh_rx_arb #(.N_IN(7), .TYPE_W(2), .ID_W(6), .FLIT_W(64), .AGE_LIMIT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        qos;
    bit [1:0]  typ;
    bit [5:0]  src;
    bit [5:0]  tgt;
    bit [63:0] data;
    int        port;
  } pkt_t;

  pkt_t q[$];
  pkt_t last;
  int   m_ptr_hi;
  int   m_ptr_lo;
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    last     = '{qos: 0, typ: 0, src: 0, tgt: 0, data: 0, port: 0};
    m_ptr_hi = 0;
    m_ptr_lo = 0;
  endfunction

  // Winner = requester of the active class closest (cyclically) at/after the pointer.
  function automatic int ref_pick(input logic [6:0] vld, input logic [6:0] qos, output bit hi_cls);
    int best;
    int bestd;
    int p;
    best   = -1;
    bestd  = N;
    hi_cls = |(vld & qos);
    p      = hi_cls ? m_ptr_hi : m_ptr_lo;
    for (int i = 0; i < N; i++) begin
      if (vld[i] && (qos[i] == hi_cls)) begin
        int d;
        d = (i - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  // One cycle: check registered outputs, drive inputs, check grant, advance model.
  task automatic step(input logic [6:0] vld, input logic [6:0] qos, input bit ordy,
                      input bit fix, input logic [63:0] fdata, output int granted);
    int   w;
    bit   hi_cls;
    bit   do_pop;
    pkt_t np;
    pkt_t exp_h;
    @(negedge clk);
    exp_h = (q.size() > 0) ? q[0] : last;
    check_eq("out_vld",  64'(bus.out_vld),  64'(q.size() > 0));
    check_eq("fifo_cnt", 64'(bus.fifo_cnt), 64'(q.size()));
    check_eq("out_qos",  64'(bus.out_qos),  64'(exp_h.qos));
    check_eq("out_type", 64'(bus.out_type), 64'(exp_h.typ));
    check_eq("out_src",  64'(bus.out_src),  64'(exp_h.src));
    check_eq("out_tgt",  64'(bus.out_tgt),  64'(exp_h.tgt));
    check_eq("out_data", bus.out_data,      exp_h.data);
    check_eq("out_port", 64'(bus.out_port), 64'(exp_h.port));
    bus.in_vld  = vld;
    bus.in_qos  = qos;
    bus.out_rdy = ordy;
    for (int i = 0; i < N; i++) begin
      bus.in_type[i*2 +: 2]  = 2'($urandom);
      bus.in_src[i*6 +: 6]   = 6'($urandom);
      bus.in_tgt[i*6 +: 6]   = 6'($urandom);
      bus.in_data[i*64 +: 64] = fix ? fdata : {$urandom, $urandom};
    end
    #1;
    w = ref_pick(vld, qos, hi_cls);
    if (q.size() >= 2) w = -1;
    check_eq("in_rdy", 64'(bus.in_rdy), (w >= 0) ? (64'd1 << w) : 64'd0);
    do_pop = (q.size() > 0) && ordy;
    if (do_pop) void'(q.pop_front());
    if (w >= 0) begin
      np.qos  = qos[w];
      np.typ  = bus.in_type[w*2 +: 2];
      np.src  = bus.in_src[w*6 +: 6];
      np.tgt  = bus.in_tgt[w*6 +: 6];
      np.data = bus.in_data[w*64 +: 64];
      np.port = w;
      q.push_back(np);
      if (hi_cls) m_ptr_hi = (w + 1) % N;
      else        m_ptr_lo = (w + 1) % N;
    end
    if (q.size() > 0) last = q[0];
    granted = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    bus.in_vld  = 7'h7F;
    bus.in_qos  = 7'h00;
    bus.out_rdy = 1'b1;
    #1;
    check_eq("rst_in_rdy",   64'(bus.in_rdy),   64'd0);
    check_eq("rst_out_vld",  64'(bus.out_vld),  64'd0);
    check_eq("rst_fifo_cnt", 64'(bus.fifo_cnt), 64'd0);
    check_eq("rst_out_data", bus.out_data,      64'd0);
    model_reset();
    @(negedge clk);
    #1;
    check_eq("rst_hold_in_rdy", 64'(bus.in_rdy), 64'd0);
    bus.in_vld = 7'h00;
    rst_n      = 1'b1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int g;
    int rr_exp [6];
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.in_vld  = '0;
    bus.in_qos  = '0;
    bus.in_type = '0;
    bus.in_src  = '0;
    bus.in_tgt  = '0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset();

    // First grant after reset with every link valid.
    step(7'h7F, 7'h00, 1'b1, 1'b0, 64'd0, g);
    check_eq("first_grant", 64'(g), 64'd0);

    // Single link with known payload; visible one cycle later.
    step(7'h08, 7'h00, 1'b1, 1'b1, 64'hA5, g);
    check_eq("single_grant", 64'(g), 64'd3);
    step(7'h00, 7'h00, 1'b1, 1'b0, 64'd0, g);
    check_eq("single_vld",  64'(bus.out_vld),  64'd1);
    check_eq("single_data", bus.out_data,      64'hA5);
    check_eq("single_port", 64'(bus.out_port), 64'd3);

    // Round-robin across links 1, 4, 6.
    do_reset();
    rr_exp = '{1, 4, 6, 1, 4, 6};
    for (int i = 0; i < 6; i++) begin
      step(7'b1010010, 7'h00, 1'b1, 1'b0, 64'd0, g);
      check_eq("rr_order", 64'(g), 64'(rr_exp[i]));
    end

    // Strict priority: link 5 (qos=1) always beats link 2 (qos=0).
    for (int i = 0; i < 8; i++) begin
      step(7'b0100100, 7'b0100000, 1'b1, 1'b0, 64'd0, g);
      check_eq("prio_grant", 64'(g), 64'd5);
    end

    // Backpressure: fill to two entries, then grants stop until popping.
    step(7'h00, 7'h00, 1'b1, 1'b0, 64'd0, g);
    step(7'h03, 7'h00, 1'b0, 1'b0, 64'd0, g);
    step(7'h03, 7'h00, 1'b0, 1'b0, 64'd0, g);
    for (int i = 0; i < 3; i++) begin
      step(7'h03, 7'h00, 1'b0, 1'b0, 64'd0, g);
      check_eq("bp_no_grant", 64'(g), 64'hFFFF_FFFF_FFFF_FFFF);
      check_eq("bp_cnt", 64'(bus.fifo_cnt), 64'd2);
    end
    for (int i = 0; i < 6; i++) begin
      step(7'h03, 7'h00, 1'b1, 1'b0, 64'd0, g);
    end

    // Random traffic with occasional mid-run resets.
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] v;
      logic [6:0] qs;
      bit         r;
      v  = 7'($urandom) & 7'($urandom | $urandom);
      qs = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'h00;
      r  = ($urandom_range(0, 3) != 0);
      step(v, qs, r, 1'b0, 64'd0, g);
      if ((i == 500) || (i == 1100)) do_reset();
    end

    step(7'h00, 7'h00, 1'b1, 1'b0, 64'd0, g);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
